carry_look_ahead: RTL and testbench

- Registered carry-lookahead adder: computes S = A + B + cin and carry-out with no ripple chain; results are registered on the clock.
- Datapath arithmetic primitive, instantiated wherever a single-cycle wide add is needed.
- Default configuration is 4 bits, which is a single lookahead group.

---
 rtl/carry_look_ahead_pkg.sv | 28 ++
 rtl/carry_look_ahead_cla_group4.sv | 26 ++
 rtl/carry_look_ahead.sv | 78 +++++++
 tb/tb_carry_look_ahead.sv | 116 +++++++++++
 4 files changed

// File: rtl/carry_look_ahead_pkg.sv
// Shared constants and two-level generate/propagate expansions for the carry-lookahead adder.
package carry_look_ahead_pkg;

    localparam int CLA_GROUP_W = 4;

    // Carries c0..c4 of one 4-bit group, every term expanded to sum-of-products.
    function automatic logic [4:0] cla4_carries(input logic [3:0] g,
                                                input logic [3:0] p,
                                                input logic       c0);
        logic [4:0] c;
        c[0] = c0;
        c[1] = g[0] | (p[0] & c0);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c0);
        return c;
    endfunction

    function automatic logic cla4_group_gen(input logic [3:0] g, input logic [3:0] p);
        return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    endfunction

    function automatic logic cla4_group_prop(input logic [3:0] p);
        return &p;
    endfunction

endpackage

// File: rtl/carry_look_ahead_cla_group4.sv
// One 4-bit lookahead group: sum bits, carry-out and group generate/propagate.
module cla_group4
    import carry_look_ahead_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] sum,
    output logic       co,
    output logic       gp,
    output logic       gg
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g   = a & b;
    assign p   = a ^ b;
    assign c   = cla4_carries(g, p, ci);
    assign sum = p ^ c[3:0];
    assign co  = c[4];
    assign gg  = cla4_group_gen(g, p);
    assign gp  = cla4_group_prop(p);

endmodule

// File: rtl/carry_look_ahead.sv
// Registered carry-lookahead adder: {cout, S} = A + B + cin, one clock of latency.
module carry_look_ahead
    import carry_look_ahead_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int GROUP = CLA_GROUP_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cin,
    output logic [WIDTH-1:0] S,
    output logic             cout
);

    localparam int NG = WIDTH / GROUP;

    logic [NG-1:0]    gg;
    logic [NG-1:0]    gp;
    logic [NG:0]      gc;
    logic [NG-1:0]    grp_co_unused;
    logic             prod;
    logic [WIDTH-1:0] s_d;
    logic [WIDTH-1:0] s_q;
    logic             cout_d;
    logic             cout_q;

    for (genvar i = 0; i < NG; i++) begin : g_grp
        cla_group4 u_grp (
            .a   (A[GROUP*i +: GROUP]),
            .b   (B[GROUP*i +: GROUP]),
            .ci  (gc[i]),
            .sum (s_d[GROUP*i +: GROUP]),
            .co  (grp_co_unused[i]),
            .gp  (gp[i]),
            .gg  (gg[i])
        );
    end

    // Second-level lookahead: each group carry-in is an OR of AND-products of
    // lower GG/GP terms and cin; the per-group co is redundant with gc[i+1].
    always_comb begin
        gc    = '0;
        prod  = 1'b0;
        gc[0] = cin;
        for (int j = 0; j < NG; j++) begin
            for (int k = 0; k <= j; k++) begin
                prod = gg[k];
                for (int m = k + 1; m <= j; m++) begin
                    prod = prod & gp[m];
                end
                gc[j+1] = gc[j+1] | prod;
            end
            prod = cin;
            for (int m = 0; m <= j; m++) begin
                prod = prod & gp[m];
            end
            gc[j+1] = gc[j+1] | prod;
        end
    end

    assign cout_d = gc[NG];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q    <= '0;
            cout_q <= 1'b0;
        end else begin
            s_q    <= s_d;
            cout_q <= cout_d;
        end
    end

    assign S    = s_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_carry_look_ahead.sv
// Directed and exhaustive check of the registered 4-bit carry-lookahead adder.
`timescale 1ns/1ps
module tb_carry_look_ahead;

    logic       clk;
    logic       rst_n;
    logic [3:0] A;
    logic [3:0] B;
    logic       cin;
    logic [3:0] S;
    logic       cout;

    int n_cmp = 0;
    int n_err = 0;

    carry_look_ahead #(.WIDTH(4), .GROUP(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .A     (A),
        .B     (B),
        .cin   (cin),
        .S     (S),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Drive at the falling edge, check the registered result just after the next rising edge.
    task automatic add_vec(input string tag, input logic [3:0] a, input logic [3:0] b,
                           input logic c, input logic [3:0] exp_s, input logic exp_co);
        @(negedge clk);
        A = a; B = b; cin = c;
        @(posedge clk);
        #1;
        expect_eq({tag, "_S"}, 32'(S), 32'(exp_s));
        expect_eq({tag, "_cout"}, 32'(cout), 32'(exp_co));
    endtask

    logic [4:0] exp_sum;
    logic       have_prev;

    initial begin
        rst_n = 1'b1;
        A = 4'b1111; B = 4'b1111; cin = 1'b1;
        @(posedge clk);
        #1;
        expect_eq("preload", 32'({cout, S}), 32'h1F);

        // Asynchronous reset mid-cycle, held across two rising edges.
        #2 rst_n = 1'b0;
        #1;
        expect_eq("rst_async", 32'({cout, S}), 32'h0);
        @(posedge clk);
        #1;
        expect_eq("rst_hold1", 32'({cout, S}), 32'h0);
        @(posedge clk);
        #1;
        expect_eq("rst_hold2", 32'({cout, S}), 32'h0);

        @(negedge clk);
        rst_n = 1'b1;
        A = 4'b0110; B = 4'b1100; cin = 1'b0;
        #1;
        expect_eq("pre_edge", 32'({cout, S}), 32'h0);
        @(posedge clk);
        #1;
        expect_eq("mixed_S", 32'(S), 32'h2);
        expect_eq("mixed_cout", 32'(cout), 32'h1);

        add_vec("cin_gen", 4'b1111, 4'b1011, 1'b1, 4'b1011, 1'b1);
        add_vec("all_prop", 4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b1);
        add_vec("zero", 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0);
        add_vec("b2b_a", 4'b0101, 4'b0011, 1'b0, 4'b1000, 1'b0);
        add_vec("b2b_b", 4'b1000, 4'b1000, 1'b0, 4'b0000, 1'b1);

        // Exhaustive sweep; each result is checked one cycle after its operands.
        have_prev = 1'b0;
        exp_sum   = '0;
        for (int i = 0; i < 512; i++) begin
            @(negedge clk);
            if (have_prev) expect_eq("sweep", 32'({cout, S}), 32'(exp_sum));
            if (i == 300) begin
                #1 rst_n = 1'b0;
                #1 expect_eq("sweep_rst", 32'({cout, S}), 32'h0);
                #1 rst_n = 1'b1;
                #1 expect_eq("sweep_rel", 32'({cout, S}), 32'h0);
            end
            A   = 4'(i);
            B   = 4'(i >> 4);
            cin = 1'(i >> 8);
            exp_sum   = 5'(A) + 5'(B) + 5'(cin);
            have_prev = 1'b1;
        end
        @(negedge clk);
        expect_eq("sweep_last", 32'({cout, S}), 32'(exp_sum));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
